alu_scheduler: RTL and testbench
================================

// Module: alu_scheduler
// PURPOSE
//  Shares one combinational ALU (ALUControl codes 0x0..0x9) among NREQ requesters.
//  Each requester hands over operand A, operand B and an ALUControl code with valid/ready.
//  The block picks one requester by round-robin and drives the ALU.
//  It captures the result and flags, then returns them on one response channel tagged with the requester id.
//  It sits between the ALU datapath and its clients (test sequencer, FSM controllers).
// PARAMETERS
//  n     4  ALU operand/result width
//  NREQ  4  number of requesters (2..8)
// PORTS
//  clk          in   1           single clock; all logic on posedge
//  rst          in   1           synchronous, active-high reset
//  req_valid    in   NREQ        per-requester request valid
//  req_ready    out  NREQ        per-requester accept (one-hot or zero)
//  req_a        in   NREQ x n    operand A per requester
//  req_b        in   NREQ x n    operand B per requester
//  req_op       in   NREQ x 4    ALUControl code per requester
//  alu_a        out  n           registered operand A to ALU
//  alu_b        out  n           registered operand B to ALU
//  alu_ctrl     out  4           registered ALUControl to ALU
//  alu_result   in   n           ALU result (combinational from alu_a/b/ctrl)
//  alu_flags    in   4           ALU flags {N,Z,C,V}
//  rsp_valid    out  1           response valid
//  rsp_ready    in   1           response consumer ready
//  rsp_id       out  clog2(NREQ) index of the served requester
//  rsp_result   out  n           captured result
//  rsp_flags    out  4           captured flags
//  rsp_err      out  1           1 = illegal op code (>0x9); result/flags forced 0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0. Reset mid-op aborts silently; no response is emitted.
//  FSM states:
//  - IDLE
//    - req_ready = onehot grant, combinational, only when any req_valid.
//    - Grant = first valid at or after the rr pointer, wrapping modulo NREQ.
//    - On accept (valid&ready): latch req_a, req_b and req_op into alu_*, and the grant index into id reg.
//    - If op > 0x9: alu_ctrl <= 0x0 (safe code) and err reg <= 1. Then go to EXEC.
//  - EXEC
//    - One settle cycle; at the end, rsp_result <= alu_result and rsp_flags <= alu_flags (both 0 if err).
//    - Go to RESP.
//  - RESP
//    - rsp_valid = 1; rsp_* held stable until rsp_ready.
//    - On rsp_valid&rsp_ready: rr pointer <= id+1 (wrap), go to IDLE.
//  req_ready = 0 in EXEC and RESP; requesters hold valid and payload stable until accepted.
//  Latency: accept in cycle T -> rsp_valid in T+2. Throughput: max one op per 3 cycles.
//  alu_a/b/ctrl hold their last values outside EXEC; no combinational path from req_* to alu_*.
//  No width growth: result is n bits as produced by the ALU; carry/overflow come only via flags.
// STRUCTURE
//  alu_sched_pkg:
//  - state_t enum {IDLE, EXEC, RESP}
//  - ALU_OP_MAX = 4'h9
//  - ALU_OP_SAFE = 4'h0
//  - flag index constants N=3, Z=2, C=1, V=0
//  Sub-module rr_arbiter #(NREQ): inputs req vector, pointer, enable; outputs onehot grant and grant index.
//  Purely combinational.
// TESTING
//  1. Reset, then req0 valid, a=3, b=5, op=0x0 -> req_ready[0] at T; rsp_valid at T+2, rsp_id=0, rsp_result=ALU(3,5,0x0).
//  2. All 4 valid every cycle, rsp_ready=1 -> grant order 0,1,2,3,0; no requester served twice before others.
//  3. req2 op=0xB -> alu_ctrl=0x0, rsp_err=1, rsp_result=0, rsp_flags=0, rsp_id=2.
//  4. rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, all req_ready=0, new requests wait; release -> IDLE next cycle.
//  5. rst=1 during EXEC -> next cycle all outputs 0, no rsp_valid; pointer 0, so req1 and req3 valid -> req1 granted first.
//  6. Only req3 valid, back-to-back with rsp_ready=1 -> accepted every 3rd cycle, pointer wraps 3->0, req3 still granted.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] ALU_OP_MAX  = 4'h9;
  localparam logic [OP_W-1:0] ALU_OP_SAFE = 4'h0;

  // Bit positions inside the {N,Z,C,V} flag nibble
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return (op > ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Request/response channels between ALU clients and the scheduler.
interface alu_scheduler_if #(
  parameter int unsigned N    = 4,
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][N-1:0]  req_a;
  logic [NREQ-1:0][N-1:0]  req_b;
  logic [NREQ-1:0][3:0]    req_op;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [N-1:0]            rsp_result;
  logic [3:0]              rsp_flags;
  logic                    rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
  );

endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  logic           found;
  logic [IDW:0]   cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      // One spare bit keeps ptr+k from overflowing before the modulo fold
      cand = {1'b0, ptr_i} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (en_i && !found && req_i[cand[IDW-1:0]]) begin
        found                 = 1'b1;
        gnt_o[cand[IDW-1:0]]  = 1'b1;
        idx_o                 = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU among NREQ requesters; round-robin grant,
// one settle cycle, then a tagged response held until consumed.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned NREQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_scheduler_if.slave      bus,
  output logic [N-1:0]        alu_a,
  output logic [N-1:0]        alu_b,
  output logic [OP_W-1:0]     alu_ctrl,
  input  logic [N-1:0]        alu_result,
  input  logic [FLAG_W-1:0]   alu_flags
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic                err_q, err_d;
  logic [N-1:0]        a_q, a_d;
  logic [N-1:0]        b_q, b_d;
  logic [OP_W-1:0]     ctrl_q, ctrl_d;
  logic [N-1:0]        res_q, res_d;
  logic [FLAG_W-1:0]   flg_q, flg_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0]     gnt;
  logic [IDW-1:0]      gidx;
  logic                arb_en;
  logic                accept;

  // Grant only offered while idle and out of reset
  assign arb_en = (state_q == IDLE) && !rst;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign accept = |(bus.req_valid & gnt);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    err_d       = err_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    res_d       = res_q;
    flg_d       = flg_q;
    rsp_valid_d = rsp_valid_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d  = bus.req_a[gidx];
          b_d  = bus.req_b[gidx];
          id_d = gidx;
          if (op_illegal(bus.req_op[gidx])) begin
            ctrl_d = ALU_OP_SAFE;
            err_d  = 1'b1;
          end else begin
            ctrl_d = bus.req_op[gidx];
            err_d  = 1'b0;
          end
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d       = err_q ? '0 : alu_result;
        flg_d       = err_q ? '0 : alu_flags;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      res_q       <= '0;
      flg_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      err_q       <= err_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      res_q       <= res_d;
      flg_q       <= flg_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flg_q;
  assign bus.rsp_err    = err_q;

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = ctrl_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed plus randomized checks of alu_scheduler against a queue-free
// behavioural model of round-robin service and a reference 4-bit ALU.
module tb_alu_scheduler;
  import alu_sched_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned NREQ = 4;
  localparam int          NR   = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   alu_a, alu_b, alu_result;
  logic [3:0]     alu_ctrl, alu_flags;

  always #5 clk = ~clk;

  alu_scheduler_if #(.N(N), .NREQ(NREQ)) bus ();

  alu_scheduler #(.N(N), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags)
  );

  // Reference ALU: returns {flags N,Z,C,V, result}
  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                  v = (a[3] == b[3]) && (r[3] != a[3]); end
      4'h1: begin r = a - b; c = (a >= b); v = (a[3] != b[3]) && (r[3] != a[3]); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~(a | b);
      4'h6: r = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      4'h7: r = a << b[1:0];
      4'h8: r = a >> b[1:0];
      4'h9: r = b;
      default: r = '0;
    endcase
    return {r[3], (r == 4'd0), c, v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_ctrl);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NREQ-1:0] vm;
  logic [3:0]      pa [NR];
  logic [3:0]      pb [NR];
  logic [3:0]      pop[NR];
  int              ptr_m;
  int              mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.req_valid = vm;
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i]  = pa[i];
      bus.req_b[i]  = pb[i];
      bus.req_op[i] = pop[i];
    end
  endtask

  task automatic new_payload(input int i, input bit legal);
    pa[i]  = 4'($urandom_range(0, 15));
    pb[i]  = 4'($urandom_range(0, 15));
    pop[i] = legal ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < NR; k++) begin
      if (vm[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
    end
    return -1;
  endfunction

  // Requester behaviour after being served: 0 drop, 1 renew, 2 random traffic
  task automatic refresh(input int g);
    int j;
    case (mode)
      0: vm[g] = 1'b0;
      1: new_payload(g, 1'b1);
      default: begin
        if ($urandom_range(0, 1) == 1) new_payload(g, 1'b0);
        else vm[g] = 1'b0;
        for (int i = 0; i < NR; i++) begin
          if (i != g && !vm[i] && $urandom_range(0, 2) == 0) begin
            vm[i] = 1'b1;
            new_payload(i, 1'b0);
          end
        end
        if (vm == '0) begin
          j = int'($urandom_range(0, NR - 1));
          vm[j] = 1'b1;
          new_payload(j, 1'b0);
        end
      end
    endcase
  endtask

  task automatic check_rsp(input int g, input logic [7:0] fr, input logic err);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_id", 32'(bus.rsp_id), 32'(g));
    chk("rsp_result", 32'(bus.rsp_result), 32'(fr[3:0]));
    chk("rsp_flags", 32'(bus.rsp_flags), 32'(fr[7:4]));
    chk("rsp_err", 32'(bus.rsp_err), 32'(err));
    chk("ready_busy", 32'(bus.req_ready), 32'd0);
  endtask

  // One full transaction from an idle scheduler; returns the accept cycle and id
  task automatic do_txn(input int stall, output int acc, output int gid);
    int         g;
    logic [3:0] a, b, op;
    logic [7:0] fr;
    logic       err;
    apply();
    #1;
    g   = exp_grant();
    gid = g;
    acc = cyc;
    if (g < 0) begin
      chk("no_pending_request", 32'(vm), 32'd1);
    end else begin
      chk("ready_idle", 32'(bus.req_ready), 32'(1) << g);
      a   = pa[g];
      b   = pb[g];
      op  = pop[g];
      err = (op > 4'h9);
      fr  = err ? 8'h00 : alu_model(a, b, op);
      @(posedge clk); #1;
      chk("alu_a", 32'(alu_a), 32'(a));
      chk("alu_b", 32'(alu_b), 32'(b));
      chk("alu_ctrl", 32'(alu_ctrl), err ? 32'd0 : 32'(op));
      chk("rsp_valid_exec", 32'(bus.rsp_valid), 32'd0);
      chk("ready_exec", 32'(bus.req_ready), 32'd0);
      refresh(g);
      apply();
      if (stall > 0) bus.rsp_ready = 1'b0;
      @(posedge clk); #1;
      check_rsp(g, fr, err);
      repeat (stall) begin
        @(posedge clk); #1;
        check_rsp(g, fr, err);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("rsp_valid_done", 32'(bus.rsp_valid), 32'd0);
      ptr_m = (g + 1) % NR;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vm  = '0;
    for (int i = 0; i < NR; i++) begin
      pa[i] = '0; pb[i] = '0; pop[i] = '0;
    end
    apply();
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    rst   = 1'b0;
    ptr_m = 0;
  endtask

  initial begin
    int acc, prev_acc, gid;
    mode = 0;
    do_reset();

    // Single request from req0: ADD 3+5
    vm = 4'b0001; pa[0] = 4'd3; pb[0] = 4'd5; pop[0] = 4'h0;
    do_txn(0, acc, gid);

    // All requesters always valid: service order 0,1,2,3,0
    do_reset();
    mode = 1;
    vm = 4'b1111;
    for (int i = 0; i < NR; i++) new_payload(i, 1'b1);
    for (int k = 0; k < 5; k++) begin
      do_txn(0, acc, gid);
      chk("rr_order", 32'(gid), 32'(k % NR));
    end

    // Illegal op from req2
    do_reset();
    mode = 0;
    vm = 4'b0100; pa[2] = 4'd7; pb[2] = 4'd6; pop[2] = 4'hB;
    do_txn(0, acc, gid);

    // Response stalled 5 cycles while other requests wait
    vm = 4'b0011;
    new_payload(0, 1'b1);
    new_payload(1, 1'b1);
    do_txn(5, acc, gid);
    do_txn(0, acc, gid);

    // Reset while in EXEC aborts; pointer back to 0
    do_reset();
    vm = 4'b0001; pa[0] = 4'd9; pb[0] = 4'd4; pop[0] = 4'h1;
    apply();
    #1;
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("abort_alu_a", 32'(alu_a), 32'd9);
    rst = 1'b1;
    vm = 4'b1010;
    new_payload(1, 1'b1);
    new_payload(3, 1'b1);
    apply();
    @(posedge clk); #1;
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_alu_a0", 32'(alu_a), 32'd0);
    chk("abort_alu_b0", 32'(alu_b), 32'd0);
    chk("abort_alu_ctrl0", 32'(alu_ctrl), 32'd0);
    chk("abort_rsp_id0", 32'(bus.rsp_id), 32'd0);
    chk("abort_rsp_err0", 32'(bus.rsp_err), 32'd0);
    chk("abort_ready0", 32'(bus.req_ready), 32'd0);
    rst   = 1'b0;
    ptr_m = 0;
    do_txn(0, acc, gid);
    chk("post_abort_grant", 32'(gid), 32'd1);

    // Only req3 valid, back-to-back: one accept every 3 cycles, pointer wraps
    vm = 4'b1000;
    new_payload(3, 1'b1);
    mode = 1;
    do_txn(0, prev_acc, gid);
    for (int k = 0; k < 3; k++) begin
      do_txn(0, acc, gid);
      chk("req3_grant", 32'(gid), 32'd3);
      chk("req3_spacing", 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
    end

    // Randomized traffic including illegal ops and response stalls
    mode = 2;
    vm = '0;
    for (int i = 0; i < NR; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        vm[i] = 1'b1;
        new_payload(i, 1'b0);
      end
    end
    if (vm == '0) begin
      vm[0] = 1'b1;
      new_payload(0, 1'b0);
    end
    for (int t = 0; t < 40; t++) begin
      do_txn(int'($urandom_range(0, 2)), acc, gid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
